lsq_mem_scheduler: RTL
======================

Name: lsq_mem_scheduler

Overview:
- In-order load/store queue and memory sequencer behind the load/store address calculator.
- Allocates entries at dispatch and captures address, mask and wdata from the calculator's lsq bus.
- Issues one data-memory access at a time from the queue head. Stores issue only when they are at ROB head.
- Returns load results (aligned, sign/zero extended) and store completions to the ROB/CDB.

Parameters:
- NSIZE, 8, queue depth; power of two, at least 2.
- ROB_DEPTH, 16, ROB entries; rob_id width = $clog2(ROB_DEPTH).
- PREG_BITS, 6, physical register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush; discards all entries.
- alloc_valid  in  1  dispatch allocates one entry.
- alloc_is_store  in  1  1 = store, 0 = load.
- alloc_funct3  in  3  RV32I load/store funct3.
- alloc_rob_id  in  $clog2(ROB_DEPTH)  owning ROB entry.
- alloc_pd  in  PREG_BITS  load destination preg.
- alloc_ready  out  1  queue not full.
- alloc_lsq_id  out  $clog2(NSIZE)  index given to the allocating op.
- calc_valid  in  1  calculator result valid (lsq_bus.ready).
- calc_lsq_id  in  $clog2(NSIZE)  target entry.
- calc_addr  in  32  effective byte address.
- calc_mask  in  4  byte mask, already shifted.
- calc_wdata  in  32  store data, already lane-aligned.
- rob_head_valid  in  1  ROB head valid.
- rob_head_id  in  $clog2(ROB_DEPTH)  ROB head index.
- dmem_addr  out  32  word-aligned address.
- dmem_rmask  out  4  read byte mask.
- dmem_wmask  out  4  write byte mask.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data.
- dmem_resp  in  1  access complete.
- ld_valid  out  1  one-cycle load result pulse.
- ld_rob_id  out  $clog2(ROB_DEPTH)  load result ROB tag.
- ld_pd  out  PREG_BITS  load result destination.
- ld_data  out  32  load result data.
- st_done_valid  out  1  one-cycle store completion pulse.
- st_done_rob_id  out  $clog2(ROB_DEPTH)  completed store ROB tag.

Behaviour:
- Reset, all outputs:
  - head = tail = 0; all entry valid and addr_rdy bits = 0; state IDLE.
  - alloc_ready = 0 while rst, otherwise !full.
  - dmem masks 0; ld_valid = 0; st_done_valid = 0; other data outputs don't-care.
- Pointers:
  - head and tail are NSIZE_BITS+1 wide.
  - full when indices are equal and the MSBs differ; empty when head == tail.
- Allocation:
  - Happens when alloc_valid && alloc_ready.
  - Writes the tail entry and clears addr_rdy; alloc_lsq_id = tail index, available combinationally the same cycle.
- Simultaneous alloc and dequeue is legal while full: alloc_ready reflects the pre-dequeue state, so no same-cycle bypass.
- Calculator write:
  - On calc_valid, sets addr_rdy and stores addr/mask/wdata into entry calc_lsq_id.
  - Write to an entry that is not valid is ignored (assertion in simulation).
- States:
  - IDLE: issue head if it is valid and addr_rdy, and either it is a load, or rob_head_valid && rob_head_id == entry.rob_id. Go to WAIT.
  - WAIT: dmem request is held stable. On dmem_resp, dequeue head and go to IDLE.
  - DRAIN: entered on flush while in WAIT. Hold the request; on dmem_resp discard the result, no pulses, go to IDLE.
- Issue timing:
  - Registered issue: dmem request outputs are driven in the cycle after the IDLE decision and held until dmem_resp.
  - Masks are 0 whenever no request is outstanding.
  - dmem_addr = {addr[31:2], 2'b00}.
  - Load: rmask = mask, wmask = 0. Store: wmask = mask, rmask = 0, wdata = entry wdata.
- Completion:
  - In the dmem_resp cycle, register the completion. ld_valid or st_done_valid pulses for exactly one cycle, one cycle after dmem_resp.
  - Load data: shift dmem_rdata right by 8*addr[1:0].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.
- Minimum throughput: one access per 3 cycles (issue, resp, idle decision). Back-to-back issue in the response cycle is not required.
- Flush:
  - Sets head = tail = 0 and clears valid bits the same cycle.
  - Any completion pulse pending for the next cycle is suppressed.
  - alloc_valid in the flush cycle is ignored.
- Reset mid-access: returns to IDLE immediately; the outstanding dmem_resp is not tracked, and the memory model resets too.

Decomposition:
- Shared package rv32i_types holds:
  - lsq_entry_t (valid, is_store, funct3, rob_id, pd, addr_rdy, addr, mask, wdata).
  - lsq_state_t enum {IDLE, WAIT, DRAIN}.
  - The existing load_f3_* and store_f3_* constants.
- One natural sub-module: load_data_align (combinational rdata shift and extension by funct3 and addr[1:0]).

Test Plan:
- Reset, then alloc a load (funct3 lw, rob 3, pd 5) and calc addr 0x100 mask 1111; dmem returns 0xDEADBEEF -> dmem_addr 0x100, rmask 1111; ld_valid with rob 3, pd 5, data 0xDEADBEEF.
- Load lb at addr 0x103, rdata 0x80FF_FFFF -> rmask 1000; ld_data 0xFFFFFF80. Repeat as lbu -> 0x00000080.
- Store sh at 0x202 with wdata 0xBEEF0000 and rob_head_id != its rob -> no dmem request. Set rob_head to match -> wmask 1100, addr 0x200; st_done_valid one cycle after resp.
- Fill all 8 entries -> alloc_ready 0. Complete head while alloc_valid is asserted -> no alloc that cycle; alloc_ready 1 the next cycle and tail wraps to index 0.
- Flush asserted during WAIT -> enter DRAIN; request held until dmem_resp; no ld_valid; queue empty, alloc_lsq_id 0 afterwards.
- Calc arrives for entry 1 before entry 0 -> no issue until entry 0 is addr_rdy; then entries issue in order 0, 1.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types for the load/store queue: entry layout, sequencer states
// and the load/store funct3 encodings.
package rv32i_types;

    // Entry tag fields are sized for the largest ROB / preg file we build;
    // the scheduler zero-extends on write and slices on read.
    localparam int LSQ_ROB_ID_MAX = 8;
    localparam int LSQ_PREG_MAX   = 8;

    localparam logic [2:0] load_f3_lb  = 3'b000;
    localparam logic [2:0] load_f3_lh  = 3'b001;
    localparam logic [2:0] load_f3_lw  = 3'b010;
    localparam logic [2:0] load_f3_lbu = 3'b100;
    localparam logic [2:0] load_f3_lhu = 3'b101;

    localparam logic [2:0] store_f3_sb = 3'b000;
    localparam logic [2:0] store_f3_sh = 3'b001;
    localparam logic [2:0] store_f3_sw = 3'b010;

    typedef struct packed {
        logic                      valid;
        logic                      is_store;
        logic [2:0]                funct3;
        logic [LSQ_ROB_ID_MAX-1:0] rob_id;
        logic [LSQ_PREG_MAX-1:0]   pd;
        logic                      addr_rdy;
        logic [31:0]               addr;
        logic [3:0]                mask;
        logic [31:0]               wdata;
    } lsq_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } lsq_state_t;

endpackage

// File: rtl/lsq_mem_scheduler_load_data_align.sv
// Load result alignment: shifts the memory word down to the addressed byte
// lane and sign/zero extends according to the load funct3.
module load_data_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            load_f3_lb:  data = {{24{shifted[7]}}, shifted[7:0]};
            load_f3_lbu: data = {24'd0, shifted[7:0]};
            load_f3_lh:  data = {{16{shifted[15]}}, shifted[15:0]};
            load_f3_lhu: data = {16'd0, shifted[15:0]};
            default:     data = shifted;
        endcase
    end

endmodule

// File: rtl/lsq_mem_scheduler.sv
// In-order load/store queue with a single-outstanding data-memory sequencer.
// Stores issue only once they reach the ROB head; loads issue as soon as ready.
module lsq_mem_scheduler
    import rv32i_types::*;
#(
    parameter int NSIZE     = 8,
    parameter int ROB_DEPTH = 16,
    parameter int PREG_BITS = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc_valid,
    input  logic                         alloc_is_store,
    input  logic [2:0]                   alloc_funct3,
    input  logic [$clog2(ROB_DEPTH)-1:0] alloc_rob_id,
    input  logic [PREG_BITS-1:0]         alloc_pd,
    output logic                         alloc_ready,
    output logic [$clog2(NSIZE)-1:0]     alloc_lsq_id,
    input  logic                         calc_valid,
    input  logic [$clog2(NSIZE)-1:0]     calc_lsq_id,
    input  logic [31:0]                  calc_addr,
    input  logic [3:0]                   calc_mask,
    input  logic [31:0]                  calc_wdata,
    input  logic                         rob_head_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0] rob_head_id,
    output logic [31:0]                  dmem_addr,
    output logic [3:0]                   dmem_rmask,
    output logic [3:0]                   dmem_wmask,
    output logic [31:0]                  dmem_wdata,
    input  logic [31:0]                  dmem_rdata,
    input  logic                         dmem_resp,
    output logic                         ld_valid,
    output logic [$clog2(ROB_DEPTH)-1:0] ld_rob_id,
    output logic [PREG_BITS-1:0]         ld_pd,
    output logic [31:0]                  ld_data,
    output logic                         st_done_valid,
    output logic [$clog2(ROB_DEPTH)-1:0] st_done_rob_id
);

    localparam int NSIZE_BITS = $clog2(NSIZE);
    localparam int ROB_BITS   = $clog2(ROB_DEPTH);

    logic [NSIZE_BITS:0]     head_reg, tail_reg;
    logic [NSIZE_BITS-1:0]   head_idx, tail_idx;
    lsq_entry_t [NSIZE-1:0]  entries;
    logic [NSIZE-1:0]        entry_valid;
    lsq_entry_t              head_entry;
    lsq_state_t              state_reg, state_next;

    logic full, alloc_go, head_can_issue, issue_go, resp_go;

    logic [31:0]             req_addr_reg, req_wdata_reg;
    logic [3:0]              req_rmask_reg, req_wmask_reg;
    logic                    cpl_is_store_reg;
    logic [2:0]              cpl_funct3_reg;
    logic [1:0]              cpl_offset_reg;
    logic [ROB_BITS-1:0]     cpl_rob_reg;
    logic [PREG_BITS-1:0]    cpl_pd_reg;
    logic [31:0]             aligned_data;

    logic                    ld_valid_reg, st_done_valid_reg;
    logic [ROB_BITS-1:0]     ld_rob_id_reg, st_done_rob_id_reg;
    logic [PREG_BITS-1:0]    ld_pd_reg;
    logic [31:0]             ld_data_reg;
    logic                    unused_tag_bits;

    assign head_idx   = head_reg[NSIZE_BITS-1:0];
    assign tail_idx   = tail_reg[NSIZE_BITS-1:0];
    assign head_entry = entries[head_idx];

    assign full         = (head_idx == tail_idx) && (head_reg[NSIZE_BITS] != tail_reg[NSIZE_BITS]);
    assign alloc_ready  = !rst && !full;
    assign alloc_lsq_id = tail_idx;
    assign alloc_go     = alloc_valid && alloc_ready && !flush;

    assign head_can_issue = head_entry.valid && head_entry.addr_rdy &&
                            (!head_entry.is_store ||
                             (rob_head_valid && rob_head_id == head_entry.rob_id[ROB_BITS-1:0]));

    // A response only retires the head when no flush has discarded the queue.
    assign resp_go = (state_reg == WAIT) && dmem_resp && !flush;

    assign unused_tag_bits = ^{head_entry.rob_id, head_entry.pd};

    always_comb begin
        state_next = state_reg;
        issue_go   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!flush && head_can_issue) begin
                    issue_go   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem_resp)
                    state_next = IDLE;
                else if (flush)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (dmem_resp)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (alloc_go)
                tail_reg <= tail_reg + 1'b1;
            if (resp_go)
                head_reg <= head_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSIZE; gi++) begin : g_entry
            lsq_entry_t entry_reg;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    entry_reg.valid    <= 1'b0;
                    entry_reg.addr_rdy <= 1'b0;
                end else begin
                    if (resp_go && head_idx == NSIZE_BITS'(gi))
                        entry_reg.valid <= 1'b0;
                    if (alloc_go && tail_idx == NSIZE_BITS'(gi)) begin
                        entry_reg.valid    <= 1'b1;
                        entry_reg.is_store <= alloc_is_store;
                        entry_reg.funct3   <= alloc_funct3;
                        entry_reg.rob_id   <= LSQ_ROB_ID_MAX'(alloc_rob_id);
                        entry_reg.pd       <= LSQ_PREG_MAX'(alloc_pd);
                        entry_reg.addr_rdy <= 1'b0;
                    end else if (calc_valid && calc_lsq_id == NSIZE_BITS'(gi) && entry_reg.valid) begin
                        entry_reg.addr_rdy <= 1'b1;
                        entry_reg.addr     <= calc_addr;
                        entry_reg.mask     <= calc_mask;
                        entry_reg.wdata    <= calc_wdata;
                    end
                end
            end

            assign entries[gi]     = entry_reg;
            assign entry_valid[gi] = entry_reg.valid;
        end
    endgenerate

    // The request and the completion context are captured at issue so a flush
    // that clears the queue cannot disturb an access already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_rmask_reg <= 4'd0;
            req_wmask_reg <= 4'd0;
        end else if (issue_go) begin
            req_addr_reg     <= {head_entry.addr[31:2], 2'b00};
            req_rmask_reg    <= head_entry.is_store ? 4'd0 : head_entry.mask;
            req_wmask_reg    <= head_entry.is_store ? head_entry.mask : 4'd0;
            req_wdata_reg    <= head_entry.wdata;
            cpl_is_store_reg <= head_entry.is_store;
            cpl_funct3_reg   <= head_entry.funct3;
            cpl_offset_reg   <= head_entry.addr[1:0];
            cpl_rob_reg      <= head_entry.rob_id[ROB_BITS-1:0];
            cpl_pd_reg       <= head_entry.pd[PREG_BITS-1:0];
        end else if (state_reg != IDLE && dmem_resp) begin
            req_rmask_reg <= 4'd0;
            req_wmask_reg <= 4'd0;
        end
    end

    load_data_align u_align (
        .rdata  (dmem_rdata),
        .funct3 (cpl_funct3_reg),
        .offset (cpl_offset_reg),
        .data   (aligned_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_valid_reg      <= 1'b0;
            st_done_valid_reg <= 1'b0;
        end else begin
            ld_valid_reg      <= resp_go && !cpl_is_store_reg;
            st_done_valid_reg <= resp_go && cpl_is_store_reg;
            if (resp_go) begin
                ld_rob_id_reg      <= cpl_rob_reg;
                ld_pd_reg          <= cpl_pd_reg;
                ld_data_reg        <= aligned_data;
                st_done_rob_id_reg <= cpl_rob_reg;
            end
        end
    end

    assign dmem_addr      = req_addr_reg;
    assign dmem_rmask     = req_rmask_reg;
    assign dmem_wmask     = req_wmask_reg;
    assign dmem_wdata     = req_wdata_reg;
    assign ld_valid       = ld_valid_reg;
    assign ld_rob_id      = ld_rob_id_reg;
    assign ld_pd          = ld_pd_reg;
    assign ld_data        = ld_data_reg;
    assign st_done_valid  = st_done_valid_reg;
    assign st_done_rob_id = st_done_rob_id_reg;

    a_calc_target_valid: assert property (@(posedge clk) disable iff (rst || flush)
        calc_valid |-> entry_valid[calc_lsq_id]);

endmodule
